vote_collector: RTL and testbench
=================================

// Module: vote_collector
// PURPOSE
//  Ballot-side front end for the combinational multi-class tally (voteMulti).
//  Accepts ballots one per cycle over a valid/ready handshake, records each
//  voter's choice into packed np/vip/vvip vectors, rejects duplicate or
//  malformed ballots, and presents a frozen ballot image plus out_valid when
//  the session closes by explicit close or idle timeout.
// PARAMETERS
//  NP_W      32    number of ordinary voters (width of np_o)
//  VIP_W     8     number of VIP voters (width of vip_o)
//  TIMEOUT   1000  idle cycles in COLLECT with no accepted ballot before auto-close
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      open (or restart) a voting session
//  close      in   1      end session, freeze image
//  in_valid   in   1      ballot present
//  in_ready   out  1      collector can take a ballot this cycle
//  in_class   in   2      0=np, 1=vip, 2=vvip, 3=illegal
//  in_idx     in   5      voter index within class
//  in_vote    in   1      1=yes, 0=no
//  np_o       out  NP_W   yes-bits of ordinary voters
//  vip_o      out  VIP_W  yes-bits of VIP voters
//  vvip_o     out  1      yes-bit of VVIP
//  cnt_o      out  6      ballots accepted this session (max NP_W+VIP_W+1=41)
//  out_valid  out  1      image frozen and valid for tally
//  err        out  1      one-cycle pulse: ballot rejected
//  timed_out  out  1      session closed by timeout (held with out_valid)
// BEHAVIOUR
//  - Reset: state=IDLE; np_o/vip_o/vvip_o/cnt_o=0; cast bitmaps=0; in_ready=0;
//    out_valid=0; err=0; timed_out=0; idle counter=0. Reset wins over all inputs.
//  - FSM IDLE -> COLLECT on start. COLLECT -> DONE on close or idle==TIMEOUT-1.
//    DONE -> COLLECT on start. start in COLLECT restarts (clears all, stays).
//  - Entry to COLLECT clears vectors, cast bitmaps, cnt_o, timed_out, idle counter.
//  - in_ready = (state==COLLECT). Handshake fires when in_valid & in_ready.
//  - Fired ballot accepted iff class<3, idx<width of class (vvip: idx==0),
//    and cast bit for (class,idx) clear. Accept: set cast bit, write in_vote
//    into vector bit, cnt_o+1, idle counter=0; visible next cycle.
//  - Fired ballot rejected otherwise: err=1 next cycle only, no state change,
//    idle counter NOT reset (junk cannot hold a session open).
//  - in_valid while not in COLLECT: ignored, no err.
//  - close and fired ballot same cycle: ballot processed, then DONE.
//  - start and fired ballot same cycle in COLLECT: restart wins, ballot dropped.
//  - Idle counter counts every COLLECT cycle without an accept; on reaching
//    TIMEOUT-1 -> DONE with timed_out=1. close same cycle: timed_out=0.
//  - DONE: out_valid=1 and vectors/cnt_o stable until start or reset.
//  - Unvoted voters read as 0 (no). Outputs registered; no comb path in->out
//    except in_ready from state.
// STRUCTURE
//  - Shared header vote_defs.v: class codes CLS_NP/CLS_VIP/CLS_VVIP/CLS_BAD,
//    state codes S_IDLE/S_COLLECT/S_DONE, NP_W/VIP_W defaults.
//  - One sub-module vote_idle_timer (clear, tick, expire; width $clog2(TIMEOUT)).
//  - FSM, cast bitmaps, vector writes, counter in vote_collector.
// TESTING
//  1 reset, start, np yes idx 0-3,16-19,28-31; vip yes 0-3; vvip yes; close ->
//    np_o=32'hf00f000f, vip_o=8'h0f, vvip_o=1, cnt_o=17, out_valid=1.
//  2 same as 1 but vvip vote=0 -> vvip_o=0, cnt_o=17; feed image to voteMulti,
//    compare res against expected both cases.
//  3 np idx 5 yes then np idx 5 no -> second gives err pulse, np_o[5]=1, cnt_o=1;
//    vip idx 9 and class 3 -> err each, cnt_o unchanged.
//  4 TIMEOUT=16: start, one ballot, then 16 idle cycles -> DONE, timed_out=1;
//    illegal ballots during idle do not delay expiry.
//  5 close with in_valid same cycle -> ballot counted, out_valid next cycle;
//    start with ballot in COLLECT -> cleared, cnt_o=0.
//  6 reset asserted mid-COLLECT after 3 ballots -> all outputs 0, IDLE,
//    in_ready=0; in_valid in IDLE/DONE -> no err, no change.

Source files
------------

// File: rtl/vote_collector_pkg.sv
// Shared definitions for the ballot collector: class codes, FSM states,
// default voter-class widths and a counter-width helper.
package vote_collector_pkg;

  localparam int unsigned NP_W_DEF  = 32;
  localparam int unsigned VIP_W_DEF = 8;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    CLS_NP   = 2'd0,
    CLS_VIP  = 2'd1,
    CLS_VVIP = 2'd2,
    CLS_BAD  = 2'd3
  } vote_cls_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } vote_state_e;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vote_idle_timer.sv
// Idle-cycle counter: cleared on session entry or accepted ballot, saturates
// at TIMEOUT-1 and flags expiry while sitting there.
module vote_idle_timer
  import vote_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int unsigned W = ctr_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = (r_cnt == LAST);

endmodule

// File: rtl/vote_collector.sv
// Ballot front end: accepts one ballot per cycle, records yes/no per voter,
// rejects duplicates/malformed ballots and freezes the image on close/timeout.
module vote_collector
  import vote_collector_pkg::*;
#(
  parameter int unsigned NP_W    = NP_W_DEF,
  parameter int unsigned VIP_W   = VIP_W_DEF,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 close,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_class,
  input  logic [4:0]           in_idx,
  input  logic                 in_vote,
  output logic [NP_W-1:0]      np_o,
  output logic [VIP_W-1:0]     vip_o,
  output logic                 vvip_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 out_valid,
  output logic                 err,
  output logic                 timed_out
);

  vote_state_e r_state, w_state_nxt;

  logic [NP_W-1:0]  r_np, r_cast_np, w_np_mask;
  logic [VIP_W-1:0] r_vip, r_cast_vip, w_vip_mask;
  logic             r_vvip, r_cast_vvip;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, r_timed_out;

  vote_cls_e w_cls;
  logic      w_legal, w_dup, w_fire, w_accept, w_reject;
  logic      w_expire, w_tmr_clear, w_tmr_tick;

  assign w_cls = vote_cls_e'(in_class);

  // One-hot voter select per class; indices beyond a class width yield an empty mask.
  always_comb begin
    w_np_mask  = '0;
    w_vip_mask = '0;
    for (int unsigned i = 0; i < NP_W; i++) begin
      w_np_mask[i] = (32'(in_idx) == i);
    end
    for (int unsigned i = 0; i < VIP_W; i++) begin
      w_vip_mask[i] = (32'(in_idx) == i);
    end
  end

  always_comb begin
    w_legal = 1'b0;
    w_dup   = 1'b0;
    case (w_cls)
      CLS_NP: begin
        w_legal = (32'(in_idx) < NP_W);
        w_dup   = |(r_cast_np & w_np_mask);
      end
      CLS_VIP: begin
        w_legal = (32'(in_idx) < VIP_W);
        w_dup   = |(r_cast_vip & w_vip_mask);
      end
      CLS_VVIP: begin
        w_legal = (in_idx == '0);
        w_dup   = r_cast_vvip;
      end
      default: ;
    endcase
  end

  // A restart in the same cycle drops the ballot silently (no accept, no err).
  assign w_fire   = in_valid && (r_state == S_COLLECT);
  assign w_accept = w_fire && !start && w_legal && !w_dup;
  assign w_reject = w_fire && !start && !(w_legal && !w_dup);

  assign w_tmr_clear = start || w_accept;
  assign w_tmr_tick  = (r_state == S_COLLECT) && !w_accept;

  vote_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tmr_clear),
    .tick   (w_tmr_tick),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (start)                  w_state_nxt = S_COLLECT;
        else if (close || w_expire) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_COLLECT);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_np        <= '0;
      r_vip       <= '0;
      r_vvip      <= 1'b0;
      r_cast_np   <= '0;
      r_cast_vip  <= '0;
      r_cast_vvip <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      case (w_cls)
        CLS_NP: begin
          r_cast_np <= r_cast_np | w_np_mask;
          r_np      <= in_vote ? (r_np | w_np_mask) : (r_np & ~w_np_mask);
        end
        CLS_VIP: begin
          r_cast_vip <= r_cast_vip | w_vip_mask;
          r_vip      <= in_vote ? (r_vip | w_vip_mask) : (r_vip & ~w_vip_mask);
        end
        CLS_VVIP: begin
          r_cast_vvip <= 1'b1;
          r_vvip      <= in_vote;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (start) begin
        r_timed_out <= 1'b0;
      end else if ((r_state == S_COLLECT) && w_expire && !close) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign np_o      = r_np;
  assign vip_o     = r_vip;
  assign vvip_o    = r_vvip;
  assign cnt_o     = r_cnt;
  assign err       = r_err;
  assign timed_out = r_timed_out;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector (TIMEOUT shortened to 16) with
// hand-computed expected images.
module tb_vote_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        close = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_class = 2'd0;
  logic [4:0]  in_idx = 5'd0;
  logic        in_vote = 1'b0;
  logic [31:0] np_o;
  logic [7:0]  vip_o;
  logic        vvip_o;
  logic [5:0]  cnt_o;
  logic        out_valid;
  logic        err;
  logic        timed_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vote_collector #(
    .NP_W   (32),
    .VIP_W  (8),
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .close     (close),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_idx    (in_idx),
    .in_vote   (in_vote),
    .np_o      (np_o),
    .vip_o     (vip_o),
    .vvip_o    (vvip_o),
    .cnt_o     (cnt_o),
    .out_valid (out_valid),
    .err       (err),
    .timed_out (timed_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock with optional ballot/start/close; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic [1:0] c, input logic [4:0] i,
                       input logic vt, input logic st, input logic cl);
    @(negedge clk);
    in_valid = v; in_class = c; in_idx = i; in_vote = vt; start = st; close = cl;
    @(posedge clk);
    #1;
    in_valid = 1'b0; start = 1'b0; close = 1'b0;
  endtask

  task automatic ballot(input logic [1:0] c, input logic [4:0] i, input logic vt);
    drive(1'b1, c, i, vt, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_close();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic full_session(input logic vv);
    do_start();
    for (int k = 0; k < 4; k++) begin
      ballot(2'd0, 5'(k), 1'b1);
      ballot(2'd0, 5'(16 + k), 1'b1);
      ballot(2'd0, 5'(28 + k), 1'b1);
      ballot(2'd1, 5'(k), 1'b1);
    end
    ballot(2'd2, 5'd0, vv);
    do_close();
  endtask

  initial begin
    // 1: reset, then full session with VVIP yes
    @(negedge clk);
    reset = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_np", np_o, 0);
    check_eq("rst_cnt", cnt_o, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_ovalid", out_valid, 0);
    check_eq("rst_err", err, 0);
    full_session(1'b1);
    check_eq("t1_np", np_o, 32'hf00f000f);
    check_eq("t1_vip", vip_o, 8'h0f);
    check_eq("t1_vvip", vvip_o, 1);
    check_eq("t1_cnt", cnt_o, 17);
    check_eq("t1_ovalid", out_valid, 1);
    check_eq("t1_ready", in_ready, 0);
    check_eq("t1_tmo", timed_out, 0);
    cyc(); cyc();
    check_eq("t1_hold_np", np_o, 32'hf00f000f);
    check_eq("t1_hold_ov", out_valid, 1);

    // 2: same with VVIP no
    full_session(1'b0);
    check_eq("t2_np", np_o, 32'hf00f000f);
    check_eq("t2_vvip", vvip_o, 0);
    check_eq("t2_cnt", cnt_o, 17);

    // 3: duplicate and malformed ballots
    do_start();
    check_eq("t3_clr_np", np_o, 0);
    check_eq("t3_clr_cnt", cnt_o, 0);
    check_eq("t3_ready", in_ready, 1);
    check_eq("t3_ovalid", out_valid, 0);
    ballot(2'd0, 5'd5, 1'b1);
    check_eq("t3_first_err", err, 0);
    ballot(2'd0, 5'd5, 1'b0);
    check_eq("t3_dup_err", err, 1);
    cyc();
    check_eq("t3_err_pulse", err, 0);
    check_eq("t3_np", np_o, 32'h20);
    check_eq("t3_cnt", cnt_o, 1);
    ballot(2'd1, 5'd9, 1'b1);
    check_eq("t3_vipidx_err", err, 1);
    ballot(2'd3, 5'd0, 1'b1);
    check_eq("t3_cls3_err", err, 1);
    ballot(2'd2, 5'd1, 1'b1);
    check_eq("t3_vvipidx_err", err, 1);
    check_eq("t3_cnt2", cnt_o, 1);
    check_eq("t3_vip", vip_o, 0);

    // 4: timeout with junk ballots not delaying expiry
    do_start();
    ballot(2'd0, 5'd1, 1'b1);
    for (int k = 0; k < 5; k++) cyc();
    for (int k = 0; k < 5; k++) ballot(2'd3, 5'd0, 1'b1);
    for (int k = 0; k < 5; k++) cyc();
    check_eq("t4_still_ready", in_ready, 1);
    check_eq("t4_not_done", out_valid, 0);
    cyc();
    check_eq("t4_done", out_valid, 1);
    check_eq("t4_tmo", timed_out, 1);
    check_eq("t4_cnt", cnt_o, 1);
    check_eq("t4_np", np_o, 32'h2);

    // 5: close with ballot, start with ballot, close at the expiry cycle
    do_start();
    check_eq("t5_tmo_clr", timed_out, 0);
    ballot(2'd0, 5'd2, 1'b1);
    drive(1'b1, 2'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    check_eq("t5_close_ov", out_valid, 1);
    check_eq("t5_close_cnt", cnt_o, 2);
    check_eq("t5_close_np", np_o, 32'hc);
    do_start();
    ballot(2'd0, 5'd7, 1'b1);
    drive(1'b1, 2'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    check_eq("t5_rst_cnt", cnt_o, 0);
    check_eq("t5_rst_np", np_o, 0);
    check_eq("t5_rst_ready", in_ready, 1);
    check_eq("t5_rst_err", err, 0);
    do_start();
    for (int k = 0; k < 15; k++) cyc();
    do_close();
    check_eq("t5_tc_ov", out_valid, 1);
    check_eq("t5_tc_tmo", timed_out, 0);

    // 6: reset mid-session, ballots outside COLLECT ignored
    do_start();
    ballot(2'd0, 5'd0, 1'b1);
    ballot(2'd1, 5'd1, 1'b1);
    ballot(2'd2, 5'd0, 1'b1);
    check_eq("t6_pre_cnt", cnt_o, 3);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_np", np_o, 0);
    check_eq("t6_vip", vip_o, 0);
    check_eq("t6_vvip", vvip_o, 0);
    check_eq("t6_cnt", cnt_o, 0);
    check_eq("t6_ready", in_ready, 0);
    check_eq("t6_ovalid", out_valid, 0);
    ballot(2'd0, 5'd4, 1'b1);
    check_eq("t6_idle_err", err, 0);
    check_eq("t6_idle_np", np_o, 0);
    check_eq("t6_idle_cnt", cnt_o, 0);
    do_start();
    ballot(2'd0, 5'd4, 1'b1);
    do_close();
    ballot(2'd0, 5'd6, 1'b1);
    check_eq("t6_done_err", err, 0);
    check_eq("t6_done_cnt", cnt_o, 1);
    check_eq("t6_done_np", np_o, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
